ccs_rdy_responder: RTL

Synthesizable receiving end of the ccs vld/rdy/dat handshake. It accepts words from a ccs initiator, with optional programmable back-pressure, into a small show-ahead FIFO. Buffered words are presented on a downstream vld/rdy port, and accepted transfers are counted. It is the RTL counterpart of the ccs initiator and is used as a DUT-side sink and as a loopback target in ccs agent benches.

---
 rtl/ccs_rdy_responder.sv | 81 ++++++++
 1 files changed

// File: rtl/ccs_rdy_responder.sv
// ccs_rdy_responder: ccs vld/rdy sink with a show-ahead FIFO, optional back-pressure and transfer counter.
// Optional stall FSM and wait_cycles port are enabled by CCS_RDY_RESPONDER_STALL_EN.
module ccs_rdy_responder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic [WIDTH-1:0] dat,
  output logic             rdy,
`ifdef CCS_RDY_RESPONDER_STALL_EN
  input  logic [7:0]       wait_cycles,
`endif
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  input  logic             out_rdy,
  output logic [31:0]      xfer_count,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] occ_q, occ_d;
  logic [31:0] xfer_count_q, xfer_count_d;
  logic rdy_q, rdy_d;
  logic push, pop;
`ifdef CCS_RDY_RESPONDER_STALL_EN
  typedef enum logic {ACCEPT, STALL} state_e;
  state_e state_q, state_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;
`endif
  always_comb begin
    push = vld && rdy_q;
    pop = out_vld && out_rdy;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    xfer_count_d = xfer_count_q + 32'(push);
`ifdef CCS_RDY_RESPONDER_STALL_EN
    state_d = state_q == STALL ? (stall_cnt_q == 8'd1 ? ACCEPT : STALL)
                               : (push && wait_cycles != 8'd0 ? STALL : ACCEPT);
    stall_cnt_d = state_q == STALL ? stall_cnt_q - 8'd1 : (push ? wait_cycles : stall_cnt_q);
    rdy_d = state_d == ACCEPT && occ_d != FULL_OCC;
`else
    rdy_d = occ_d != FULL_OCC;
`endif
  end
  // rdy is precomputed from next state so it stays registered yet tracks full exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q <= '0;
      xfer_count_q <= '0;
      rdy_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef CCS_RDY_RESPONDER_STALL_EN
      state_q <= ACCEPT;
      stall_cnt_q <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q <= occ_d;
      xfer_count_q <= xfer_count_d;
      rdy_q <= rdy_d;
      if (push) mem_q[wr_ptr_q] <= dat;
`ifdef CCS_RDY_RESPONDER_STALL_EN
      state_q <= state_d;
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end
  assign rdy = rdy_q;
  assign out_vld = occ_q != '0;
  assign full = occ_q == FULL_OCC;
  assign out_dat = mem_q[rd_ptr_q];
  assign xfer_count = xfer_count_q;
endmodule
